img_lut_loader: RTL and testbench

Bulk-load sequencer and write arbiter for the image LUT. It accepts a stream of mapped pixel values and writes them to every LUT address in ascending order, one entry per accepted beat. It shares the LUT write port with the single-entry CSR write path and holds one pending CSR write while a bulk load is in progress. It sits between the LUT CSR block, the table source (DMA/stream) and the LUT write port. Loads are gated to vertical blanking so the active frame never sees a half-written table.

---
 rtl/img_lut_loader.sv | 80 ++++++++
 tb/tb_img_lut_loader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/img_lut_loader.sv
// img_lut_loader: bulk LUT load sequencer and CSR/stream write arbiter.
// Define IMG_LUT_LOADER_FRAME_SYNC_EN to gate loads to vertical blanking.
module img_lut_loader #(
   parameter int PX_WIDTH = 10
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic [PX_WIDTH-1:0] csr_orig_px_i,
   input  logic [PX_WIDTH-1:0] csr_mod_px_i,
   input  logic                csr_wr_stb_i,
   input  logic                load_start_i,
   input  logic [PX_WIDTH-1:0] load_data_i,
   input  logic                load_valid_i,
   output logic                load_ready_o,
   input  logic                blank_i,
   output logic [PX_WIDTH-1:0] lut_orig_px_o,
   output logic [PX_WIDTH-1:0] lut_mod_px_o,
   output logic                lut_wr_stb_o,
   output logic                busy_o,
   output logic                done_o
);
   typedef enum logic [1:0] {IDLE, WAIT_BLANK, LOAD, DONE} state_t;
   state_t state, state_nx;
   logic [PX_WIDTH-1:0] cnt, cnt_nx, pend_a, pend_a_nx, pend_d, pend_d_nx;
   logic [PX_WIDTH-1:0] a_nx, d_nx;
   logic pend, pend_nx, gate, hs, cap, stb_nx, pend_out;
`ifdef IMG_LUT_LOADER_FRAME_SYNC_EN
   assign gate = blank_i;
`else
   assign gate = 1'b1;
`endif
   assign load_ready_o = (state == LOAD) && gate;
   assign hs = load_valid_i && load_ready_o;
   // CSR writes arriving mid-load are parked so they land after the bulk table
   assign cap = csr_wr_stb_i && (state == WAIT_BLANK || state == LOAD);
   assign pend_out = (state == DONE) && !csr_wr_stb_i;
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:       state_nx = load_start_i ? WAIT_BLANK : IDLE;
         WAIT_BLANK: state_nx = gate ? LOAD : WAIT_BLANK;
         LOAD:       state_nx = !gate ? WAIT_BLANK : (hs && cnt == '1) ? DONE : LOAD;
         default:    state_nx = IDLE;
      endcase
   end
   always_comb begin
      cnt_nx = (state == IDLE && load_start_i) ? '0 : hs ? cnt + 1'b1 : cnt;
      pend_nx = cap ? 1'b1 : (state == DONE) ? 1'b0 : pend;
      pend_a_nx = cap ? csr_orig_px_i : pend_a;
      pend_d_nx = cap ? csr_mod_px_i : pend_d;
      stb_nx = hs || (state == IDLE && csr_wr_stb_i) || (state == DONE && (pend || csr_wr_stb_i));
      a_nx = hs ? cnt : pend_out ? pend_a : csr_orig_px_i;
      d_nx = hs ? load_data_i : pend_out ? pend_d : csr_mod_px_i;
   end
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         cnt <= '0;
         pend <= 1'b0;
         pend_a <= '0;
         pend_d <= '0;
         lut_orig_px_o <= '0;
         lut_mod_px_o <= '0;
         lut_wr_stb_o <= 1'b0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         cnt <= cnt_nx;
         pend <= pend_nx;
         pend_a <= pend_a_nx;
         pend_d <= pend_d_nx;
         lut_orig_px_o <= stb_nx ? a_nx : lut_orig_px_o;
         lut_mod_px_o <= stb_nx ? d_nx : lut_mod_px_o;
         lut_wr_stb_o <= stb_nx;
         busy_o <= state != IDLE;
         done_o <= state == DONE;
      end
endmodule

// File: tb/tb_img_lut_loader.sv
// tb_img_lut_loader: scoreboard bench for img_lut_loader with PX_WIDTH = 4.
module tb_img_lut_loader;
   localparam int W = 4;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [W-1:0] csr_orig = '0, csr_mod = '0, load_data = '0, lut_orig, lut_mod;
   logic csr_stb = 1'b0, load_start = 1'b0, load_valid = 1'b0, blank = 1'b0;
   logic load_ready, lut_stb, busy, done;
   logic [7:0] exp_q[$];
   logic [7:0] e;
   int n_vec = 0, n_err = 0, beat = 0, dmode = 0;
   bit acc = 0;
   always #5 clk = ~clk;
   img_lut_loader #(.PX_WIDTH(W)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .csr_orig_px_i(csr_orig), .csr_mod_px_i(csr_mod),
      .csr_wr_stb_i(csr_stb), .load_start_i(load_start), .load_data_i(load_data),
      .load_valid_i(load_valid), .load_ready_o(load_ready), .blank_i(blank),
      .lut_orig_px_o(lut_orig), .lut_mod_px_o(lut_mod), .lut_wr_stb_o(lut_stb),
      .busy_o(busy), .done_o(done)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
      end
   endtask
   function automatic logic [3:0] f(input int i);
      case (dmode)
         0: f = 4'(15 - i);
         1: f = 4'(i) ^ 4'hA;
         default: f = 4'(i * 5 + 3);
      endcase
   endfunction
   always @(negedge clk)
      if (rst_n && lut_stb === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_strobe: got addr %0d data %0d, required no write", lut_orig, lut_mod);
         end else begin
            e = exp_q.pop_front();
            chk("lut_write", {lut_orig, lut_mod}, e);
         end
      end
   task automatic adv();
      @(negedge clk);
      if (acc) beat++;
      acc = 0;
      load_start = 0;
      csr_stb = 0;
   endtask
   task automatic drv(input logic v, input logic b);
      load_valid = v && beat < 16;
      load_data = f(beat);
      blank = b;
      #1 acc = load_valid && load_ready;
   endtask
   task automatic begin_load(input int m);
      dmode = m;
      beat = 0;
      for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), f(i)});
      adv();
      drv(0, 1);
      load_start = 1;
   endtask
   task automatic finish_load(input bit tog, input bit pend);
      bit prev = 0, got = 0;
      for (int k = 0; k < 200 && !got; k++) begin
         adv();
         if (done === 1'b1) begin
            got = 1;
            chk("done_after_last_strobe", prev, 1);
            chk("busy_in_done", busy, 1);
            if (pend) begin
               chk("pend_stb_in_done", lut_stb, 1);
               chk("pend_write", {lut_orig, lut_mod}, {4'd2, 4'd1});
            end else chk("no_stb_in_done", lut_stb, 0);
         end
         prev = lut_stb;
         drv(tog ? !k[0] : 1'b1, 1);
      end
      chk("done_seen", got, 1);
      adv();
      drv(0, 1);
      chk("done_one_cycle", done, 0);
      chk("busy_falls", busy, 0);
      chk("queue_drained", exp_q.size(), 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end
   initial begin
      int nd;
      repeat (3) @(negedge clk);
      chk("rst_stb", lut_stb, 0);
      chk("rst_orig", lut_orig, 0);
      chk("rst_mod", lut_mod, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", load_ready, 0);
      rst_n = 1;
      adv();
      chk("idle_busy", busy, 0);
      exp_q.push_back({4'd3, 4'd9});
      drv(0, 0);
      csr_orig = 3;
      csr_mod = 9;
      csr_stb = 1;
      adv();
      chk("csr_latency", lut_stb, 1);
      chk("csr_busy", busy, 0);
      drv(0, 0);
      adv();
      chk("csr_stb_one_cycle", lut_stb, 0);
      chk("csr_hold", {lut_orig, lut_mod}, {4'd3, 4'd9});
      begin_load(0);
      finish_load(0, 0);
      begin_load(1);
      for (int k = 0; k < 200 && beat < 5; k++) begin
         adv();
         drv(1, beat < 5);
      end
      chk("drop_at_beat", beat, 5);
      for (int k = 0; k < 10; k++) begin
         adv();
`ifdef IMG_LUT_LOADER_FRAME_SYNC_EN
         chk("gap_no_strobe", lut_stb, 0);
`endif
         drv(1, k == 9);
`ifdef IMG_LUT_LOADER_FRAME_SYNC_EN
         if (k < 9) chk("gap_ready_low", load_ready, 0);
`endif
      end
      finish_load(0, 0);
      begin_load(0);
      exp_q.push_back({4'd2, 4'd1});
      for (int k = 0; k < 4; k++) begin
         adv();
         drv(1, 1);
      end
      adv();
      drv(1, 1);
      csr_orig = 2;
      csr_mod = 7;
      csr_stb = 1;
      adv();
      drv(1, 1);
      csr_orig = 2;
      csr_mod = 1;
      csr_stb = 1;
      finish_load(0, 1);
      begin_load(2);
      for (int k = 0; k < 6; k++) begin
         adv();
         drv(k[0], 1);
      end
      adv();
      drv(1, 1);
      load_start = 1;
      finish_load(1, 0);
      nd = 0;
      for (int k = 0; k < 20; k++) begin
         adv();
         nd += int'(done);
         drv(0, 1);
      end
      chk("second_start_ignored", nd, 0);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
